// File: rtl/apb_req_bridge_if.sv
// ============================================================================
// Module   : APB_BUS
// Purpose  : APB bus bundle shared by the request bridge (Master) and the
//            peripheral decoder/mux (Slave).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/apb_req_bridge.sv
// ============================================================================
// Module   : apb_req_bridge
// Purpose  : Core req/gnt/rvalid port to APB master, single outstanding
//            transfer, out-of-window addresses answered locally with an error.
//            Optional ACCESS-phase timeout: define APB_BRIDGE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_req_bridge #(
  parameter int unsigned                APB_ADDR_WIDTH = 32,
  parameter int unsigned                APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0]  WIN_START      = 32'h1A10_0000,
  parameter logic [APB_ADDR_WIDTH-1:0]  WIN_END        = 32'h1A11_7FFF,
  parameter int unsigned                TIMEOUT_CYCLES = 256
) (
  input  wire logic                      clk,
  input  wire logic                      rst_n,
  input  wire logic                      req_i,
  input  wire logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  wire logic                      we_i,
  input  wire logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]      rdata_o,
  output logic                           err_o,
  APB_BUS.Master                         apb_master
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_gnt;
  logic                      w_in_win;
  logic                      w_timeout;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_rvalid;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_err;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_req_bridge: TIMEOUT_CYCLES out of range 2..65535");
  end

  // rst_n gating keeps gnt_o low for the whole reset window
  assign w_gnt    = req_i & rst_n & ((r_state == S_IDLE) | (r_state == S_RESP));
  assign w_in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_ACCESS && !apb_master.pready) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // pready in the final counted cycle still wins (timeout requires !pready)
  assign w_timeout = (r_state == S_ACCESS) && !apb_master.pready &&
                     (r_tmo_cnt == c_tmo_last);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (w_gnt) w_state_nxt = w_in_win ? S_SETUP : S_RESP;
        else       w_state_nxt = S_IDLE;
      end
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (apb_master.pready || w_timeout) w_state_nxt = S_RESP;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // APB controls are decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_paddr  <= addr_i;
        r_pwrite <= we_i;
        r_pwdata <= wdata_i;
      end
      r_psel    <= (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
      r_penable <= (w_state_nxt == S_ACCESS);
      r_rvalid  <= (w_state_nxt == S_RESP);
      if (w_gnt && !w_in_win) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else if (r_state == S_ACCESS && apb_master.pready) begin
        r_rdata <= r_pwrite ? '0 : apb_master.prdata;
        r_err   <= apb_master.pslverr;
      end else if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign gnt_o              = w_gnt;
  assign rvalid_o           = r_rvalid;
  assign rdata_o            = r_rdata;
  assign err_o              = r_err;
  assign apb_master.paddr   = r_paddr;
  assign apb_master.pwdata  = r_pwdata;
  assign apb_master.pwrite  = r_pwrite;
  assign apb_master.psel    = r_psel;
  assign apb_master.penable = r_penable;

endmodule

`default_nettype wire

// File: tb/tb_apb_req_bridge.sv
// ============================================================================
// Module   : tb_apb_req_bridge
// Purpose  : Self-checking bench for apb_req_bridge (vector table, random
//            transfers against a reference model, multi-cycle corner cases).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apb_req_bridge;

  localparam logic [31:0] WS = 32'h1A10_0000;
  localparam logic [31:0] WE = 32'h1A11_7FFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apb ();

  apb_req_bridge #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .WIN_START      (WS),
    .WIN_END        (WE),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .addr_i     (addr),
    .we_i       (we),
    .wdata_i    (wdata),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .err_o      (err),
    .apb_master (apb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    int          waits;
    logic [31:0] prd;
    logic        se;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_npsel;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          npsel;
  } exp_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: window test plus fixed 3-cycle APB latency plus wait states
  function automatic exp_t model(input logic [31:0] a, input logic w, input int waits,
                                 input logic [31:0] prd, input logic se);
    exp_t e;
    if (a >= WS && a <= WE) begin
      e.lat   = 3 + waits;
      e.rdata = w ? 32'h0 : prd;
      e.err   = se;
      e.npsel = 2 + waits;
    end else begin
      e.lat   = 1;
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.npsel = 0;
    end
    return e;
  endfunction

  // One transfer: request on a negedge, then act as APB slave and observe
  task automatic run_txn(input string nm, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input int waits, input logic [31:0] prd,
                         input logic se, output int lat, output logic [31:0] rd,
                         output logic er, output int npsel, output int nbad);
    int wc;
    lat = -1; npsel = 0; nbad = 0; wc = 0; rd = '0; er = 1'b0;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; wdata = wd;
    #1;
    check({nm, " gnt"}, 32'(gnt), 32'h1);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      req = 1'b0; addr = $urandom; we = 1'($urandom); wdata = $urandom;
      if (apb.psel) begin
        npsel++;
        if (apb.paddr !== a || apb.pwrite !== w || apb.pwdata !== wd) nbad++;
        if ((k == 1) == apb.penable) nbad++;
      end
      if (rvalid) begin
        lat = k; rd = rdata; er = err;
      end
      if (apb.psel && apb.penable) begin
        if (wc == waits) begin
          apb.pready = 1'b1; apb.prdata = prd; apb.pslverr = se;
        end else begin
          apb.pready = 1'b0; apb.prdata = $urandom; apb.pslverr = 1'($urandom); wc++;
        end
      end else begin
        apb.pready = 1'($urandom); apb.prdata = $urandom; apb.pslverr = 1'($urandom);
      end
    end
    if (lat < 0) check({nm, " response within bound"}, 32'h0, 32'h1);
    @(posedge clk);
    #1;
    apb.pready = 1'b0;
    check({nm, " rvalid one cycle"}, 32'(rvalid), 32'h0);
    check({nm, " rdata hold"}, rdata, rd);
    check({nm, " err hold"}, 32'(err), 32'(er));
  endtask

  task automatic check_txn(input string nm, input int lat, input logic [31:0] rd,
                           input logic er, input int npsel, input int nbad, input exp_t e);
    check({nm, " latency"}, 32'(lat), 32'(e.lat));
    check({nm, " rdata"}, rd, e.rdata);
    check({nm, " err"}, 32'(er), 32'(e.err));
    check({nm, " psel cycles"}, 32'(npsel), 32'(e.npsel));
    check({nm, " apb protocol"}, 32'(nbad), 32'h0);
  endtask

  initial begin
    int          lat, npsel, nbad, first, second, nacc, nrv;
    logic [31:0] rd;
    logic        er, saw;
    exp_t        e;
    logic [31:0] a;
    logic        w, se;
    int          waits;

    vecs[0] = '{32'h1A10_1008, 1'b0, 32'h0,         0, 32'hCAFE_0001, 1'b0, 3, 32'hCAFE_0001, 1'b0, 2};
    vecs[1] = '{32'h1A10_3004, 1'b1, 32'h0000_00A5, 3, 32'hDEAD_BEEF, 1'b0, 6, 32'h0,         1'b0, 5};
    vecs[2] = '{32'h1A20_0000, 1'b0, 32'h0,         0, 32'h1234_5678, 1'b0, 1, 32'h0,         1'b1, 0};
    vecs[3] = '{32'h1A10_2000, 1'b0, 32'h0,         1, 32'h5555_AAAA, 1'b1, 4, 32'h5555_AAAA, 1'b1, 3};
    vecs[4] = '{32'h1A10_0000, 1'b0, 32'h0,         0, 32'h0BAD_F00D, 1'b0, 3, 32'h0BAD_F00D, 1'b0, 2};
    vecs[5] = '{32'h1A11_7FFF, 1'b1, 32'hFFFF_0000, 2, 32'h7777_7777, 1'b1, 5, 32'h0,         1'b1, 4};
    vecs[6] = '{32'h1A11_8000, 1'b1, 32'h1,         0, 32'h0,         1'b0, 1, 32'h0,         1'b1, 0};
    vecs[7] = '{32'h1A0F_FFFF, 1'b0, 32'h0,         0, 32'h0,         1'b0, 1, 32'h0,         1'b1, 0};

    rst_n = 1'b0; req = 1'b1; addr = 32'h1A10_1000; we = 1'b1; wdata = 32'hFFFF_FFFF;
    apb.pready = 1'b1; apb.prdata = 32'hFFFF_FFFF; apb.pslverr = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset psel", 32'(apb.psel), 32'h0);
    check("reset penable", 32'(apb.penable), 32'h0);
    check("reset pwrite", 32'(apb.pwrite), 32'h0);
    check("reset paddr", apb.paddr, 32'h0);
    check("reset pwdata", apb.pwdata, 32'h0);
    check("reset rvalid", 32'(rvalid), 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset err", 32'(err), 32'h0);
    req = 1'b0; apb.pready = 1'b0; apb.pslverr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].wd, vecs[i].waits,
              vecs[i].prd, vecs[i].se, lat, rd, er, npsel, nbad);
      e.lat = vecs[i].exp_lat; e.rdata = vecs[i].exp_rdata;
      e.err = vecs[i].exp_err; e.npsel = vecs[i].exp_npsel;
      check_txn($sformatf("vec%0d", i), lat, rd, er, npsel, nbad, e);
    end

    // Randomised transfers against the reference model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       a = WS - 32'd1;
        1:       a = WS;
        2:       a = WE;
        3:       a = WE + 32'd1;
        4:       a = WS + $urandom_range(0, 32'h0001_7FFF);
        default: a = $urandom;
      endcase
      w = 1'($urandom); se = 1'($urandom); waits = $urandom_range(0, 4);
      rd = $urandom;
      e = model(a, w, waits, rd, se);
      run_txn($sformatf("rnd%0d", i), a, w, $urandom, waits, rd, se, lat, rd, er, npsel, nbad);
      check_txn($sformatf("rnd%0d", i), lat, rd, er, npsel, nbad, e);
    end

    // Back-to-back reads with req held
    first = -1; second = -1;
    @(negedge clk);
    req = 1'b1; addr = 32'h1A10_0100; we = 1'b0; wdata = 32'h0;
    #1;
    check("b2b gnt1", 32'(gnt), 32'h1);
    for (int k = 1; k <= 20 && second < 0; k++) begin
      @(posedge clk);
      #1;
      if (rvalid) begin
        if (first < 0) begin
          first = k;
          check("b2b gnt2 with rvalid1", 32'(gnt), 32'h1);
          check("b2b rdata1", rdata, 32'h1111_0000);
        end else begin
          second = k;
          check("b2b rdata2", rdata, 32'h2222_0000);
          req = 1'b0;
        end
      end
      apb.pready = apb.psel && apb.penable;
      apb.prdata = (first < 0) ? 32'h1111_0000 : 32'h2222_0000;
    end
    check("b2b first latency", 32'(first), 32'd3);
    check("b2b spacing", 32'(second - first), 32'd3);
    @(posedge clk);
    #1;
    apb.pready = 1'b0;
    check("b2b no third psel", 32'(apb.psel), 32'h0);
    check("b2b no third rvalid", 32'(rvalid), 32'h0);

    // Reset pulsed during ACCESS
    @(negedge clk);
    req = 1'b1; addr = 32'h1A10_0200; we = 1'b1; wdata = 32'h0000_3C3C;
    apb.pready = 1'b0;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    check("rst-mid in access", 32'(apb.psel && apb.penable), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst-mid psel drop", 32'(apb.psel), 32'h0);
    check("rst-mid penable drop", 32'(apb.penable), 32'h0);
    apb.pready = 1'b1;
    repeat (2) @(negedge clk);
    apb.pready = 1'b0;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      saw = saw | rvalid | apb.psel;
    end
    check("rst-mid no rvalid/psel", 32'(saw), 32'h0);
    e = model(32'h1A10_0300, 1'b0, 1, 32'hABCD_0123, 1'b0);
    run_txn("post-rst", 32'h1A10_0300, 1'b0, 32'h0, 1, 32'hABCD_0123, 1'b0,
            lat, rd, er, npsel, nbad);
    check_txn("post-rst", lat, rd, er, npsel, nbad, e);

    // Slave never ready
    nacc = 0; nrv = 0; lat = -1;
    @(negedge clk);
    req = 1'b1; addr = 32'h1A10_0400; we = 1'b0; wdata = 32'h0;
    apb.pready = 1'b0; apb.prdata = 32'hFFFF_FFFF;
    #1;
    check("stall gnt", 32'(gnt), 32'h1);
`ifdef APB_BRIDGE_TIMEOUT_EN
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      req = 1'b0;
      apb.pslverr = 1'($urandom);
      if (apb.psel && apb.penable) nacc++;
      if (rvalid) begin
        lat = k;
        check("timeout psel low", 32'(apb.psel), 32'h0);
        check("timeout err", 32'(err), 32'h1);
        check("timeout rdata", rdata, 32'h0);
      end
    end
    check("timeout access cycles", 32'(nacc), 32'd4);
    check("timeout latency", 32'(lat), 32'd6);
`else
    for (int k = 1; k <= 1001; k++) begin
      @(posedge clk);
      #1;
      req = 1'b0;
      apb.pslverr = 1'($urandom);
      if (apb.psel && apb.penable) nacc++;
      if (rvalid) nrv++;
    end
    check("stall access cycles", 32'(nacc), 32'd1000);
    check("stall no rvalid", 32'(nrv), 32'h0);
    check("stall still in access", 32'(apb.psel && apb.penable), 32'h1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
`endif
    apb.pslverr = 1'b0;
    e = model(32'h1A10_0500, 1'b1, 0, 32'h0, 1'b0);
    run_txn("post-stall", 32'h1A10_0500, 1'b1, 32'h0000_0042, 0, 32'h0, 1'b0,
            lat, rd, er, npsel, nbad);
    check_txn("post-stall", lat, rd, er, npsel, nbad, e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_req_bridge.md
Name: apb_req_bridge

Overview:
- Upstream neighbour of the SoC peripheral APB bus: converts the core-side request/grant/rvalid data port into APB master transfers.
- The output drives the APB_BUS Master modport that feeds the peripheral address decoder/mux.
- Single outstanding transaction.
- Rejects addresses outside the peripheral window locally, with an error response and no APB access.

Parameters:
- APB_ADDR_WIDTH, 32, APB address width; must match the APB_BUS instance.
- APB_DATA_WIDTH, 32, APB data width; must match the APB_BUS instance.
- WIN_START, 32'h1A10_0000, lowest address forwarded to APB (inclusive).
- WIN_END, 32'h1A11_7FFF, highest address forwarded to APB (inclusive).
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit; used only with APB_BRIDGE_TIMEOUT_EN; legal range 2..65535.

Ports:
- clk  input  1  single clock for bridge and APB.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  1  core request valid.
- addr_i  input  APB_ADDR_WIDTH  byte address.
- we_i  input  1  1 = write, 0 = read.
- wdata_i  input  APB_DATA_WIDTH  write data.
- gnt_o  output  1  request accepted this cycle (combinational).
- rvalid_o  output  1  one-cycle response strobe; issued for reads and writes.
- rdata_o  output  APB_DATA_WIDTH  read data; valid with rvalid_o.
- err_o  output  1  error flag; valid with rvalid_o.
- apb_master  interface  APB_BUS.Master  paddr, pwdata, pwrite, psel, penable out; prdata, pready, pslverr in.

Behaviour:
- Reset (async, rst_n=0): state IDLE. psel, penable, pwrite, paddr, pwdata, rvalid_o, rdata_o, err_o all 0. gnt_o=0 while in reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- gnt_o = req_i & (state==IDLE | state==RESP). On gnt, capture addr_i, we_i and wdata_i into registers.
- Transitions:
  - IDLE/RESP + gnt + in-window → SETUP.
  - IDLE/RESP + gnt + out-of-window → RESP with err_o=1, rdata_o=0. No APB activity.
  - IDLE/RESP, no gnt → IDLE.
  - SETUP → ACCESS, unconditionally.
  - ACCESS + pready → RESP.
  - ACCESS + !pready → stay in ACCESS.
- In-window test: WIN_START <= addr <= WIN_END, full-width unsigned compare.
- APB outputs are registered:
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - paddr, pwrite and pwdata are stable from SETUP until the ACCESS cycle where pready=1.
  - psel=penable=0 in IDLE and RESP.
  - pwdata is the captured wdata, also for reads.
- On ACCESS with pready=1:
  - rdata_o <= prdata for reads, 0 for writes.
  - err_o <= pslverr.
  - rvalid_o <= 1 in the next cycle (RESP) for exactly one cycle.
- Latency: gnt at cycle T; SETUP T+1; ACCESS T+2; with zero-wait pready, rvalid at T+3. Each APB wait state adds one cycle.
- Out-of-window: gnt at T, rvalid/err at T+1.
- Back-to-back: a new request granted in RESP goes to SETUP at the next cycle. Peak throughput is one APB transfer per 3 cycles.
- rdata_o and err_o hold their value after RESP until the next response. rvalid_o is 0 outside RESP.
- req_i may drop without gnt; nothing is captured and no effect.
- pready and pslverr are ignored outside ACCESS.
- Reset asserted mid-transfer: psel/penable drop immediately (async). No rvalid is ever issued for the aborted transfer.

Optional Feature:
- Macro: APB_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - If the counter reaches TIMEOUT_CYCLES-1 with pready still 0, the bridge leaves ACCESS → RESP: psel=penable=0, err_o=1, rdata_o=0.
  - A pready arriving in that same cycle takes priority and completes normally.
- Undefined: no counter logic; ACCESS waits indefinitely for pready.

Test Plan:
- Read 0x1A10_1008, slave zero-wait, prdata=32'hCAFE_0001 → psel at T+1; penable at T+2; rvalid=1, rdata=32'hCAFE_0001, err=0 at T+3.
- Write 0x1A10_3004, data 32'h0000_00A5, slave inserts 3 wait states → pwrite=1, paddr/pwdata stable for 5 cycles; rvalid at T+6, err=0, rdata=0.
- Read 0x1A20_0000 (out of window) → psel never asserted; rvalid=1, err=1, rdata=0 at T+1.
- Two back-to-back reads with req_i held, slave zero-wait → second gnt coincides with first rvalid; second rvalid exactly 3 cycles after the first.
- Read with pslverr=1 on the pready cycle → rvalid with err=1, rdata=prdata. Separately, rst_n pulsed low during ACCESS → psel/penable go to 0 at once, no rvalid, next request proceeds normally.
- With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready tied 0 → psel drops after 4 ACCESS cycles; rvalid, err=1. Without the macro, the same stimulus keeps the bridge in ACCESS for 1000 cycles with no rvalid.
